// File: rtl/sevenseg_scan.sv
// Four-digit common-anode seven-segment scanner: per-frame digit snapshot, guard
// interval between slots, leading-zero blanking and flashing on sticky overflow.
module sevenseg_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 4,
    parameter int unsigned FLASH_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_in,
    input  logic       blank_en,
    input  logic       ovf_in,
    input  logic       ovf_clr,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       ovf_flag
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FL_W  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [FL_W-1:0]  FL_LAST   = FL_W'(FLASH_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic [3:0]       snap_dp_q, snap_dp_d;
    logic             first_q, first_d;
    logic [FL_W-1:0]  fcnt_q, fcnt_d;
    logic             foff_q, foff_d;
    logic             flag_q, flag_d;
    logic [3:0]       an_n_q, an_n_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic             dp_n_q, dp_n_d;

    logic             tick;
    logic             capture;
    logic             active;
    logic             blank;
    logic [3:0]       cur;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;

        // Snapshot at frame start and on the first edge out of reset
        capture   = first_q || (tick && (idx_q == 2'd3));
        snap_d    = capture ? {d3, d2, d1, d0} : snap_q;
        snap_dp_d = capture ? dp_in : snap_dp_q;
        first_d   = 1'b0;

        if (ovf_clr)     flag_d = 1'b0;
        else if (ovf_in) flag_d = 1'b1;
        else             flag_d = flag_q;

        fcnt_d = fcnt_q;
        foff_d = foff_q;
        if (ovf_clr || !flag_q) begin
            fcnt_d = '0;
            foff_d = 1'b0;
        end else if (tick) begin
            if (fcnt_q == FL_LAST) begin
                fcnt_d = '0;
                foff_d = ~foff_q;
            end else begin
                fcnt_d = fcnt_q + FL_W'(1);
            end
        end

        cur = snap_q[idx_q];
        case (idx_q)
            2'd3:    blank = (snap_q[3] == 4'd0);
            2'd2:    blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
            2'd1:    blank = (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0) && (snap_q[1] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && blank_en;

        // Anodes stay dark during the guard window and the flash-off phase
        active  = (cnt_q >= CNT_GUARD) && !foff_q;
        an_n_d  = active ? ~(4'b0001 << idx_q) : 4'hF;
        seg_n_d = (!active || blank) ? 7'h7F : seg_decode(cur);
        dp_n_d  = active ? ~snap_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            snap_q    <= '0;
            snap_dp_q <= 4'd0;
            first_q   <= 1'b1;
            fcnt_q    <= '0;
            foff_q    <= 1'b0;
            flag_q    <= 1'b0;
            an_n_q    <= 4'hF;
            seg_n_q   <= 7'h7F;
            dp_n_q    <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            first_q   <= first_d;
            fcnt_q    <= fcnt_d;
            foff_q    <= foff_d;
            flag_q    <= flag_d;
            an_n_q    <= an_n_d;
            seg_n_q   <= seg_n_d;
            dp_n_q    <= dp_n_d;
        end
    end

    assign an_n     = an_n_q;
    assign seg_n    = seg_n_q;
    assign dp_n     = dp_n_q;
    assign ovf_flag = flag_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a cycle-indexed reference model queues the
// expected outputs at each rising edge, a monitor compares them on falling edges.
module tb_sevenseg_scan;

    localparam int unsigned RD = 8;
    localparam int unsigned GD = 2;
    localparam int unsigned FT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d0, d1, d2, d3, dp_in;
    logic       blank_en, ovf_in, ovf_clr;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n, ovf_flag;

    always #5 clk = ~clk;

    sevenseg_scan #(.REFRESH_DIV(RD), .GUARD(GD), .FLASH_TICKS(FT)) dut (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp_in(dp_in),
        .blank_en(blank_en), .ovf_in(ovf_in), .ovf_clr(ovf_clr),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .ovf_flag(ovf_flag)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       flag;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] model_seg(input int v);
        if (v > 9) return 7'h3F;
        return seg_tab[v];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state expressed as cycles since reset release
    int  k;
    int  snap [4];
    int  sdp  [4];
    bit  mflag;
    int  ftick;

    always @(posedge clk) begin
        exp_t e;
        int   slot, digit;
        bit   off, on, blanked, tick, nflag;
        if (rst) begin
            k = 0; mflag = 0; ftick = 0;
            for (int j = 0; j < 4; j++) begin snap[j] = 0; sdp[j] = 0; end
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.flag = 1'b0;
        end else begin
            slot  = k % RD;
            digit = (k / RD) % 4;
            off   = mflag && (((ftick / FT) % 2) == 1);
            on    = (slot >= GD) && !off;
            blanked = blank_en && (digit > 0);
            for (int j = 0; j < 4; j++)
                if (j >= digit && snap[j] != 0) blanked = 0;
            e.an  = on ? 4'(~(1 << digit)) : 4'hF;
            e.seg = (on && !blanked) ? model_seg(snap[digit]) : 7'h7F;
            e.dp  = on ? (sdp[digit] == 0) : 1'b1;
            tick  = (slot == RD - 1);
            nflag = ovf_clr ? 1'b0 : (ovf_in ? 1'b1 : mflag);
            if (ovf_clr || !mflag) ftick = 0;
            else if (tick) ftick++;
            e.flag = nflag;
            if (k == 0 || (k % (4 * RD)) == 4 * RD - 1) begin
                snap[0] = int'(d0); snap[1] = int'(d1); snap[2] = int'(d2); snap[3] = int'(d3);
                for (int j = 0; j < 4; j++) sdp[j] = int'(dp_in[j]);
            end
            mflag = nflag;
            k++;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare every cycle away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst) begin
                check("an_n", 32'(an_n), 32'(e.an));
                check("seg_n", 32'(seg_n), 32'(e.seg));
                check("dp_n", 32'(dp_n), 32'(e.dp));
                check("ovf_flag", 32'(ovf_flag), 32'(e.flag));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic set_digits(input int a3, input int a2, input int a1, input int a0);
        d3 = 4'(a3); d2 = 4'(a2); d1 = 4'(a1); d0 = 4'(a0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"}, 32'(an_n), 32'h0000_000F);
        check({tag, "_seg"}, 32'(seg_n), 32'h0000_007F);
        check({tag, "_dp"}, 32'(dp_n), 32'd1);
        check({tag, "_flag"}, 32'(ovf_flag), 32'd0);
    endtask

    initial begin
        rst = 1'b1; dp_in = 4'd0; blank_en = 1'b0; ovf_in = 1'b0; ovf_clr = 1'b0;
        set_digits(1, 2, 3, 4);
        cycles(3);
        check_reset_vals("reset");
        rst = 1'b0;

        // Plain scan of 1,2,3,4
        cycles(4 * RD * 2);

        // Leading-zero blanking with a decimal point on digit 2
        set_digits(0, 5, 3, 9); dp_in = 4'b0100; blank_en = 1'b1;
        cycles(4 * RD * 2);
        set_digits(0, 0, 0, 0);
        cycles(4 * RD * 2);

        // Mid-frame change of d0 is deferred to the next frame
        set_digits(1, 2, 3, 4); dp_in = 4'd0; blank_en = 1'b0;
        cycles(4 * RD + RD + 3);
        d0 = 4'd7;
        cycles(4 * RD * 2);

        // Overflow flag, flashing, clear, and clear-wins
        ovf_in = 1'b1;
        @(posedge clk); #1;
        check("ovf_set", 32'(ovf_flag), 32'd1);
        ovf_in = 1'b0;
        cycles(RD * 20);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        check("ovf_clr", 32'(ovf_flag), 32'd0);
        ovf_clr = 1'b0;
        cycles(RD * 3);
        ovf_in = 1'b1; ovf_clr = 1'b1;
        @(posedge clk); #1;
        check("ovf_both", 32'(ovf_flag), 32'd0);
        ovf_in = 1'b0; ovf_clr = 1'b0;
        cycles(RD * 4);

        // Non-BCD digit shows a dash
        d0 = 4'd12;
        cycles(4 * RD * 2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0)
                set_digits(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 19) == 0) d3 = 4'd0;
            if ($urandom_range(0, 19) == 0) d2 = 4'd0;
            if ($urandom_range(0, 29) == 0) dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) blank_en = ~blank_en;
            ovf_in  = ($urandom_range(0, 149) == 0);
            ovf_clr = ($urandom_range(0, 399) == 0);
            cycles(1);
        end
        ovf_in = 1'b0; ovf_clr = 1'b0;

        // Reset mid-slot at idx 2, with a pending overflow flag
        rst = 1'b1; cycles(2); rst = 1'b0;
        ovf_in = 1'b1; cycles(1); ovf_in = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        set_digits(9, 8, 7, 6); dp_in = 4'b0001; blank_en = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(4 * RD * 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
